// File: rtl/dmem_lsu_if.sv
// Core-side request/response and data-memory port bundle for dmem_lsu.
// The LSU connects through the slave modport; the requester/memory side uses master.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one request at a time, word accesses to data memory,
// load extension and read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | read word in flight, extract on next edge
// ST_RD | read old word for sub-word merge
// ST_WR | memory write cycle
// RSP   | one-cycle response pulse
module dmem_lsu #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_lsu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RSP} state_e;

  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic        fault;
  logic [31:0] load_ext;

  always_comb begin
    fault = 1'b0;
    if (bus.req_addr > MAX_ADDR) begin
      fault = 1'b1;
    end else if (bus.req_we) begin
      fault = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      fault = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
  end

  always_comb begin
    load_ext = bus.mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b001:  load_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  load_ext = {24'h0, bus.mem_rdata[7:0]};
      3'b101:  load_ext = {16'h0, bus.mem_rdata[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          funct3_d    = bus.req_funct3;
          wdata_d     = bus.req_wdata[15:0];
          mem_addr_d  = bus.req_addr;
          rsp_rdata_d = 32'h0;
          rsp_fault_d = fault;
          if (fault) begin
            state_d = RSP;
          end else if (!bus.req_we) begin
            state_d = LOAD;
          end else if (bus.req_funct3 == 3'b010) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      LOAD: begin
        rsp_rdata_d = load_ext;
        state_d     = RSP;
      end
      ST_RD: begin
        // sub-word data always lands in the low lanes of the addressed word
        if (funct3_q == 3'b000) begin
          mem_wdata_d = {bus.mem_rdata[31:8], wdata_q[7:0]};
        end else begin
          mem_wdata_d = {bus.mem_rdata[31:16], wdata_q};
        end
        state_d = ST_WR;
      end
      ST_WR:   state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      wdata_q     <= 16'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // decoded straight from state so reset drops them without waiting for a clock
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.mem_we    = (state_q == ST_WR);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: byte-array memory model, response scoreboard
// and edge-counting monitors for writes, handshakes and responses.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt = 0;
  int   hs_cnt = 0;
  int   rv_cnt = 0;
  int   viol_cnt = 0;
  logic [31:0] last_wd = 32'h0;
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  exp_t sb[$];

  dmem_lsu_if bus ();

  dmem_lsu #(.DEPTH_BYTES(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_addr + 32'(i) < 32'd1024)
        bus.mem_rdata[8*i +: 8] = mem[10'(bus.mem_addr + 32'(i))];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wd <= bus.mem_wdata;
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_addr + 32'(i) < 32'd1024)
          mem[10'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
      end
    end
    if (bus.req_valid && bus.req_ready) hs_cnt <= hs_cnt + 1;
    if (bus.rsp_valid) rv_cnt <= rv_cnt + 1;
    if (bus.rsp_valid && bus.req_ready) viol_cnt <= viol_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat,
                        input int exp_wes, input logic chk_wd, input logic [31:0] exp_wd);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    int   we_base;
    e.rdata = exp_rd;
    e.fault = exp_flt;
    e.lat   = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    we_base = we_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
    chk({tag, "_rdata"}, bus.rsp_rdata, got.rdata);
    chk({tag, "_fault"}, 32'(bus.rsp_fault), 32'(got.fault));
    chk({tag, "_writes"}, 32'(we_cnt - we_base), 32'(exp_wes));
    if (chk_wd) chk({tag, "_mem_wdata"}, last_wd, exp_wd);
  endtask

  initial begin
    int hs_base;
    int rv_base;
    int we_base;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    #3 rst_n = 1'b1;

    do_req("sw40", 1'b1, 3'b010, 32'd40, 32'h11223344, 32'h0, 1'b0, 2, 1, 1'b1, 32'h11223344);
    do_req("lw40", 1'b0, 3'b010, 32'd40, 32'h0, 32'h11223344, 1'b0, 2, 0, 1'b0, 32'h0);
    do_req("sb40", 1'b1, 3'b000, 32'd40, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 1, 1'b1, 32'h112233AB);
    do_req("sh41", 1'b1, 3'b001, 32'd41, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1'b1, 32'h0011BEEF);
    do_req("lw40m", 1'b0, 3'b010, 32'd40, 32'h0, 32'h11BEEFAB, 1'b0, 2, 0, 1'b0, 32'h0);

    do_req("sw100", 1'b1, 3'b010, 32'd100, 32'h0000807F, 32'h0, 1'b0, 2, 1, 1'b1, 32'h0000807F);
    do_req("lb100", 1'b0, 3'b000, 32'd100, 32'h0, 32'h0000007F, 1'b0, 2, 0, 1'b0, 32'h0);
    do_req("lb101", 1'b0, 3'b000, 32'd101, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 1'b0, 32'h0);
    do_req("lbu101", 1'b0, 3'b100, 32'd101, 32'h0, 32'h00000080, 1'b0, 2, 0, 1'b0, 32'h0);
    do_req("lh100", 1'b0, 3'b001, 32'd100, 32'h0, 32'hFFFF807F, 1'b0, 2, 0, 1'b0, 32'h0);
    do_req("lhu100", 1'b0, 3'b101, 32'd100, 32'h0, 32'h0000807F, 1'b0, 2, 0, 1'b0, 32'h0);

    do_req("flt_lw1021", 1'b0, 3'b010, 32'd1021, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
    do_req("flt_sw1024", 1'b1, 3'b010, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
    do_req("flt_ld011", 1'b0, 3'b011, 32'd40, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
    do_req("flt_st100", 1'b1, 3'b100, 32'd40, 32'h5A5A5A5A, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
    do_req("flt_hiaddr", 1'b0, 3'b010, 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
    do_req("lw40_after_flt", 1'b0, 3'b010, 32'd40, 32'h0, 32'h11BEEFAB, 1'b0, 2, 0, 1'b0, 32'h0);

    do_req("sw1020", 1'b1, 3'b010, 32'd1020, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 1'b1, 32'hCAFEF00D);
    do_req("lw1020", 1'b0, 3'b010, 32'd1020, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 1'b0, 32'h0);

    @(posedge clk); #1;
    hs_base = hs_cnt;
    rv_base = rv_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'd40;
    repeat (9) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("held_accepts", 32'(hs_cnt - hs_base), 32'd3);
    chk("held_responses", 32'(rv_cnt - rv_base), 32'd3);
    chk("ready_during_rsp", 32'(viol_cnt), 32'd0);

    @(posedge clk); #1;
    rv_base = rv_cnt;
    we_base = we_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd40;
    bus.req_wdata  = 32'h00000055;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_mem_addr", bus.mem_addr, 32'h0);
    chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
    chk("abort_rdata", bus.rsp_rdata, 32'h0);
    chk("abort_fault", 32'(bus.rsp_fault), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", 32'(we_cnt - we_base), 32'd0);
    chk("abort_no_rsp", 32'(rv_cnt - rv_base), 32'd0);
    chk("abort_word_kept", {mem[43], mem[42], mem[41], mem[40]}, 32'h11BEEFAB);
    do_req("lw40_after_abort", 1'b0, 3'b010, 32'd40, 32'h0, 32'h11BEEFAB, 1'b0, 2, 0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that drives the byte-addressed data memory from the core side. It accepts one load or store request at a time over a valid/ready handshake and issues word accesses to the memory port. For loads it extracts and sign- or zero-extends byte, halfword or word data. For sub-word stores it performs a read-modify-write, because the memory always writes four bytes.

## Interface
Parameters:
- DEPTH_BYTES, 1024, size of the data memory in bytes; legal request addresses are 0..DEPTH_BYTES-4

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; handshake when req_valid && req_ready at posedge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data (LSBs used for SB/SH)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid; request rejected, memory untouched
- mem_addr  out  32  memory byte address (registered)
- mem_wdata  out  32  memory write word, little-endian (registered)
- mem_we  out  1  memory write enable; memory commits on the falling edge within the cycle it is high
- mem_rdata  in  32  combinational little-endian read word at mem_addr..mem_addr+3

## Operation
- States: IDLE, LOAD, ST_RD, ST_WR, RSP.
- IDLE:
  - On handshake, latch we/funct3/addr/wdata and drive mem_addr = req_addr.
  - Fault check: req_addr > DEPTH_BYTES-4, a load funct3 outside {000,001,010,100,101}, or a store funct3 outside {000,001,010}. A faulting request goes to RSP with rsp_fault=1.
  - Otherwise: load -> LOAD; SW -> ST_WR with mem_wdata = req_wdata; SB/SH -> ST_RD.
- LOAD:
  - mem_we=0. At the next posedge capture mem_rdata and extract:
    - LB: sign-extend [7:0]
    - LBU: zero-extend [7:0]
    - LH: sign-extend [15:0]
    - LHU: zero-extend [15:0]
    - LW: all 32 bits
  - Go to RSP.
- ST_RD:
  - mem_we=0. At the next posedge build the merge word and go to ST_WR:
    - SB: {mem_rdata[31:8], wdata[7:0]}
    - SH: {mem_rdata[31:16], wdata[15:0]}
- ST_WR: mem_we=1 for exactly this cycle. Next state is RSP.
- RSP: rsp_valid=1 for exactly this cycle, mem_we=0. Next state is IDLE.
- Unaligned addresses are legal. Sub-word data always occupies the lowest byte lanes of the word at req_addr.
- mem_addr and mem_wdata hold their last values outside active states.
- A faulting request never asserts mem_we.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Latency from the accepting posedge T to rsp_valid high:
  - load: T+2
  - SW: T+2
  - SB/SH: T+3
  - fault: T+1
- Throughput: a new request can be accepted one cycle after rsp_valid (in IDLE). Back-to-back loads accept every 3 cycles.
- req_ready is low in every state except IDLE. req_valid asserted in other states is ignored; the requester must hold it.
- A store's write completes at the falling edge of its ST_WR cycle. A load accepted immediately afterward reads the new data.
- Reset asserted mid-operation forces IDLE and drops mem_we and rsp_valid immediately.
  - If reset asserts before the ST_WR falling edge, no write occurs.
  - No response is generated for the aborted request.
- Boundary addresses:
  - req_addr = DEPTH_BYTES-4 is legal.
  - req_addr = DEPTH_BYTES-3 faults.
  - Addresses at or above 2^31 fault; there is no wrap.

## Test plan
- Reset, then SW 0x11223344 to addr 40, then LW from 40:
  - mem_we high one cycle with mem_wdata=0x11223344.
  - Load response is 0x11223344, rsp_fault=0, with rsp_valid 2 cycles after each accept.
- Memory holds 0x11223344 at addr 40; issue SB 0xAB to 40, then SH 0xBEEF to 41, then LW from 40:
  - Result is 0x11BEEFAB.
  - Each sub-word store shows one read cycle then one write cycle; rsp_valid arrives 3 cycles after accept.
- Word 0x0000807F at addr 100:
  - LB -> 0x0000007F; LB at 101 -> 0xFFFFFF80; LBU at 101 -> 0x00000080.
  - LH -> 0xFFFF807F; LHU -> 0x0000807F.
- Fault cases (DEPTH_BYTES=1024), each giving rsp_valid at T+1 with rsp_fault=1, rsp_rdata=0 and mem_we never asserted:
  - LW at 1021
  - SW at 1024
  - load funct3 = 011
  - store funct3 = 100
- Legal boundary: LW at 1020 succeeds with rsp_fault=0.
- Handshake and reset:
  - Hold req_valid high continuously: req_ready is high only in IDLE and exactly one request is accepted per transaction.
  - Assert rst_n low during the ST_RD cycle of an SB: the target word is unchanged, and all outputs return to reset values immediately.
